// File: rtl/coherence_bus_arbiter_pkg.sv
// coherence_bus_arbiter_pkg: shared bus op, cache state and arbiter FSM types
package coherence_bus_arbiter_pkg;
  typedef enum logic [1:0] {INVALID = 2'd0, SHARED = 2'd1, EXCLUSIVE = 2'd2, MODIFIED = 2'd3} cache_state_e;
  typedef enum logic [1:0] {BUS_RD = 2'd0, BUS_RDX = 2'd1, BUS_UPGR = 2'd2} bus_op_e;
  typedef enum logic [2:0] {IDLE, SNOOP, RESP, FLUSH, WB, MEMRD, DONE} arb_state_e;
  function automatic bus_op_e decode_op(input logic [1:0] op);
    return op == 2'd2 ? BUS_UPGR : op == 2'd1 ? BUS_RDX : BUS_RD;
  endfunction
endpackage

// File: rtl/coherence_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first requester at/after ptr wins
module rr_arbiter
  import coherence_bus_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt
);
  localparam int PW = $clog2(N);
  logic [N-1:0]  w_rot;
  logic [PW-1:0] w_first;
  logic [PW:0]   w_sum;
  // rotate requests so ptr sits at bit 0, pick the lowest, rotate the index back
  always_comb begin
    w_rot = N'({i_req, i_req} >> i_ptr);
    w_first = '0;
    for (int k = N - 1; k >= 0; k--) w_first = w_rot[k] ? PW'(k) : w_first;
    w_sum = {1'b0, i_ptr} + {1'b0, w_first};
    o_gnt = (|i_req) ? N'(1) << (w_sum >= (PW+1)'(N) ? w_sum - (PW+1)'(N) : w_sum) : '0;
  end
endmodule

// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter: MESI snooping-bus controller; COH_ARB_PERF_EN adds perf counters
module coherence_bus_arbiter
  import coherence_bus_arbiter_pkg::*;
#(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_W     = 28,
  parameter int BLOCK_W    = 128
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NUM_CACHES-1:0]        i_req,
  input  logic [2*NUM_CACHES-1:0]      i_req_op,
  input  logic [ADDR_W*NUM_CACHES-1:0] i_req_addr,
  output logic [NUM_CACHES-1:0]        o_gnt,
  output logic                         o_snoop_valid,
  output logic [1:0]                   o_snoop_op,
  output logic [ADDR_W-1:0]            o_snoop_addr,
  output logic [NUM_CACHES-1:0]        o_snoop_src,
  input  logic [NUM_CACHES-1:0]        i_snoop_hit,
  input  logic [NUM_CACHES-1:0]        i_snoop_dirty,
  input  logic                         i_flush_valid,
  input  logic [BLOCK_W-1:0]           i_flush_data,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [BLOCK_W-1:0]           o_mem_wdata,
  input  logic                         i_mem_ack,
  input  logic [BLOCK_W-1:0]           i_mem_rdata,
  output logic [NUM_CACHES-1:0]        o_done,
  output logic [1:0]                   o_done_state,
  output logic [BLOCK_W-1:0]           o_done_data
`ifdef COH_ARB_PERF_EN
  ,
  output logic [31:0]                  o_perf_txn,
  output logic [31:0]                  o_perf_flush,
  output logic [31:0]                  o_perf_c2c_hit
`endif
);
  localparam int PW = $clog2(NUM_CACHES);
  arb_state_e              r_state;
  bus_op_e                 r_op, r_snoop_op;
  cache_state_e            r_fill, r_done_state, w_fill;
  logic [ADDR_W-1:0]       r_addr, r_snoop_addr, r_mem_addr;
  logic [NUM_CACHES-1:0]   r_gnt, r_done, w_arb, w_hit, w_dirty;
  logic [PW-1:0]           r_ptr, r_idx, w_arb_idx, w_ptr_nxt;
  logic                    r_snoop_valid, r_mem_req, r_mem_we;
  logic [BLOCK_W-1:0]      r_mem_wdata, r_done_data;

  rr_arbiter #(.N(NUM_CACHES)) u_rr (.i_req(i_req), .i_ptr(r_ptr), .o_gnt(w_arb));

  // one-hot winner to index for operand selection and pointer advance
  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < NUM_CACHES; i++) w_arb_idx = w_arb[i] ? PW'(i) : w_arb_idx;
  end

  assign w_hit     = i_snoop_hit & ~r_gnt;
  assign w_dirty   = i_snoop_dirty & ~r_gnt;
  assign w_fill    = r_op != BUS_RD ? MODIFIED : (|w_hit) ? SHARED : EXCLUSIVE;
  assign w_ptr_nxt = r_idx == PW'(NUM_CACHES - 1) ? '0 : r_idx + PW'(1);

  // transaction sequencer; r_snoop_valid doubles as the wait for the response cycle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_op <= BUS_RD;
      r_snoop_op <= BUS_RD;
      r_fill <= INVALID;
      r_done_state <= INVALID;
      r_addr <= '0;
      r_snoop_addr <= '0;
      r_mem_addr <= '0;
      r_gnt <= '0;
      r_done <= '0;
      r_ptr <= '0;
      r_idx <= '0;
      r_snoop_valid <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_wdata <= '0;
      r_done_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (|i_req) begin
          r_gnt <= w_arb;
          r_idx <= w_arb_idx;
          r_op <= decode_op(i_req_op[2*w_arb_idx +: 2]);
          r_addr <= i_req_addr[ADDR_W*w_arb_idx +: ADDR_W];
          r_state <= SNOOP;
        end
        SNOOP: begin
          r_snoop_valid <= 1'b1;
          r_snoop_op <= r_op;
          r_snoop_addr <= r_addr;
          r_state <= RESP;
        end
        RESP: if (r_snoop_valid) r_snoop_valid <= 1'b0;
        else begin
          r_fill <= w_fill;
          if (r_op == BUS_UPGR) begin
            r_done <= r_gnt;
            r_gnt <= '0;
            r_done_state <= MODIFIED;
            r_state <= DONE;
          end else if (|w_dirty) r_state <= FLUSH;
          else begin
            r_mem_req <= 1'b1;
            r_mem_we <= 1'b0;
            r_mem_addr <= r_addr;
            r_state <= MEMRD;
          end
        end
        FLUSH: if (i_flush_valid) begin
          r_mem_req <= 1'b1;
          r_mem_we <= 1'b1;
          r_mem_addr <= r_addr;
          r_mem_wdata <= i_flush_data;
          r_state <= WB;
        end
        WB: if (i_mem_ack) begin
          r_mem_req <= 1'b0;
          r_mem_we <= 1'b0;
          r_done <= r_gnt;
          r_gnt <= '0;
          r_done_state <= r_fill;
          r_done_data <= r_mem_wdata;
          r_state <= DONE;
        end
        MEMRD: if (i_mem_ack) begin
          r_mem_req <= 1'b0;
          r_done <= r_gnt;
          r_gnt <= '0;
          r_done_state <= r_fill;
          r_done_data <= i_mem_rdata;
          r_state <= DONE;
        end
        DONE: begin
          r_done <= '0;
          r_ptr <= w_ptr_nxt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt         = r_gnt;
  assign o_snoop_valid = r_snoop_valid;
  assign o_snoop_op    = r_snoop_op;
  assign o_snoop_addr  = r_snoop_addr;
  assign o_snoop_src   = r_gnt;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_done        = r_done;
  assign o_done_state  = r_done_state;
  assign o_done_data   = r_done_data;

  a_single_owner: assert property (@(posedge i_clk) disable iff (i_reset)
    (r_state == RESP && !r_snoop_valid) |-> $onehot0(w_dirty));

`ifdef COH_ARB_PERF_EN
  logic [31:0] r_perf_txn, r_perf_flush, r_perf_c2c;
  // saturating event counters for completions, owner flushes and cache-to-cache read hits
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_perf_txn <= '0;
      r_perf_flush <= '0;
      r_perf_c2c <= '0;
    end else begin
      if (r_state == DONE && ~&r_perf_txn) r_perf_txn <= r_perf_txn + 32'd1;
      if (r_state == FLUSH && i_flush_valid && ~&r_perf_flush) r_perf_flush <= r_perf_flush + 32'd1;
      if (r_state == RESP && !r_snoop_valid && r_op == BUS_RD && (|w_hit) && ~&r_perf_c2c) r_perf_c2c <= r_perf_c2c + 32'd1;
    end
  end
  assign o_perf_txn     = r_perf_txn;
  assign o_perf_flush   = r_perf_flush;
  assign o_perf_c2c_hit = r_perf_c2c;
`endif
endmodule
